lsu_ctrl: RTL and testbench

Load/store controller that issues byte, halfword and word accesses from the core datapath to the word-organised data memory (`data_mem`). It is the initiator side of the `addr`/`wd`/`we`/`rd` memory interface. It handles byte-lane selection, sign/zero extension on loads, read-modify-write merging for sub-word stores, and alignment checking. It sits between the execute stage and `data_mem`, with a single-outstanding request/response handshake.

---
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues byte/half/word accesses to data_mem with lane select,
// load extension and read-modify-write for sub-word stores. Optional build macro:
// LSU_MISALIGN_TRAP_EN (misaligned half/word accesses error instead of being aligned).
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  // state  | meaning
  // IDLE   | ready for a request
  // RD     | memory word read (load result or RMW base)
  // WR     | single-cycle write to data_mem
  // ERR    | rejected request, no memory access
  // RESP   | one-cycle response pulse
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_ERR, S_RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       hold_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              illegal;
  logic [ADDR_W-1:0] addr_al;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept = req_valid && (state == S_IDLE);

  always_comb begin
    addr_al = req_addr;
    if (req_size == SZ_HALF)
      addr_al[0] = 1'b0;
    else if (req_size == SZ_WORD)
      addr_al[1:0] = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign illegal = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign illegal = (req_size == SZ_ILL);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal)
            state_nxt = S_ERR;
          else if (!req_we || (req_size != SZ_WORD))
            state_nxt = S_RD;
          else
            state_nxt = S_WR;
        end
      end
      S_RD:    state_nxt = we_q ? S_WR : S_RESP;
      S_WR:    state_nxt = S_RESP;
      S_ERR:   state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_al;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= illegal;
        wdata_q <= req_wdata;
      end
      if (state == S_RD) begin
        hold_q  <= mem_rd;
        rdata_q <= load_ext;
      end
    end
  end

  assign lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_rd[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_rd;
    endcase
  end

  // Sub-word stores patch only the addressed lane(s) of the word read in RD.
  always_comb begin
    merged = hold_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign word_idx = addr_q >> 2;

  always_comb begin
    req_ready  = (state == S_IDLE);
    mem_we     = (state == S_WR);
    mem_wd     = (state == S_WR) ? merged : 32'h0;
    mem_addr   = 32'(word_idx);
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && err_q;
    resp_rdata = ((state == S_RESP) && !we_q && !err_q) ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized traffic against a word-array
// model of data_mem; honours LSU_MISALIGN_TRAP_EN when defined for both files.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  assign mem_rd = dmem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[3:0]] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one request computed from byte arithmetic on ref_mem.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata,
                           output logic [31:0] nw, output int lat, output int idx);
    logic [31:0] a, w, v, mask;
    int sh;
    err = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) err = 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'd0) err = 1'b1;
`endif
    a = addr;
    if (size == 2'd1) a = a & ~32'd1;
    if (size == 2'd2) a = a & ~32'd3;
    idx = int'(a / 4) % 16;
    w = ref_mem[idx];
    sh = 8 * int'(a % 4);
    if (size == 2'd0) begin
      mask = 32'hFF;
      v = (w >> sh) & mask;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      mask = 32'hFFFF;
      v = (w >> sh) & mask;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      mask = 32'hFFFFFFFF;
      v = w;
    end
    nw = (w & ~(mask << sh)) | ((wdata & mask) << sh);
    rdata = (err || we) ? 32'h0 : v;
    lat = (!err && we && size != 2'd2) ? 3 : 2;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err,
                        output logic [31:0] got_wd);
    logic e, wr_cyc;
    logic [31:0] er, nw;
    int lat, idx, waited;
    model_req(we, size, uns, addr, wdata, e, er, nw, lat, idx);
    got_rdata = 32'h0; got_err = 1'b0; got_wd = 32'h0;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 8) begin @(negedge clk); waited++; end
    if (!req_ready) begin
      chk("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      wr_cyc = !e && we && (c == lat - 1);
      chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, c == lat});
      chk("mem_we", {31'h0, mem_we}, {31'h0, wr_cyc});
      chk("mem_wd", mem_wd, wr_cyc ? nw : 32'h0);
      if (!e && c < lat) chk("mem_addr", mem_addr, addr >> 2);
      if (mem_we) got_wd = mem_wd;
      if (c == lat) begin
        chk("resp_err", {31'h0, resp_err}, {31'h0, e});
        chk("resp_rdata", resp_rdata, er);
        got_rdata = resp_rdata;
        got_err = resp_err;
      end
      // busy-time requests must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_addr = $urandom;
      req_wdata = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_after", {31'h0, req_ready}, 32'h1);
    chk("resp_valid_after", {31'h0, resp_valid}, 32'h0);
    if (!e && we) begin
      ref_mem[idx] = nw;
      chk("mem_content", dmem[idx], nw);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    dmem[idx] <= val;
    ref_mem[idx] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, wd;
    logic er;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    preload(0, 32'hAAAABBBB);
    preload(1, 32'h12345678);
    do_req(0, 2'd0, 0, 32'h0, 0, r, er, wd);
    chk("tp_lb_signed", r, 32'hFFFFFFBB);
    do_req(0, 2'd0, 1, 32'h0, 0, r, er, wd);
    chk("tp_lb_unsigned", r, 32'h000000BB);
    do_req(0, 2'd1, 0, 32'h2, 0, r, er, wd);
    chk("tp_lh_signed", r, 32'hFFFFAAAA);
    do_req(1, 2'd0, 0, 32'h5, 32'h0000005A, r, er, wd);
    chk("tp_sb_wd", wd, 32'h12345A78);
    do_req(0, 2'd2, 0, 32'h4, 0, r, er, wd);
    chk("tp_lw_after_sb", r, 32'h12345A78);
    do_req(1, 2'd2, 0, 32'h10, 32'h55667788, r, er, wd);
    chk("tp_sw_wd", wd, 32'h55667788);
    do_req(0, 2'd2, 0, 32'h10, 0, r, er, wd);
    chk("tp_lw_after_sw", r, 32'h55667788);
    do_req(0, 2'd2, 0, 32'h6, 0, r, er, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("tp_misalign_err", {31'h0, er}, 32'h1);
    chk("tp_misalign_rdata", r, 32'h0);
`else
    chk("tp_misalign_err", {31'h0, er}, 32'h0);
    chk("tp_misalign_rdata", r, 32'h12345A78);
`endif
    do_req(1, 2'd3, 0, 32'h8, 32'hFFFFFFFF, r, er, wd);
    chk("tp_size11_err", {31'h0, er}, 32'h1);

    // reset during the WR cycle of a sub-word store
    preload(2, 32'hCAFEF00D);
    @(negedge clk);
    req_we = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h9;
    req_wdata = 32'h11; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("rst_mid_we_before", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we_drop", {31'h0, mem_we}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_resp", {31'h0, resp_valid}, 32'h0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_after_resp", {31'h0, resp_valid}, 32'h0);
      chk("rst_after_ready", {31'h0, req_ready}, 32'h1);
    end
    chk("rst_mem_unchanged", dmem[2], 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, r, er, wd);
    end
    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
